ahbl_apb_bridge_mc: RTL and testbench

- Parametrised AHB-Lite slave to multi-slot APB3/APB4 master bridge; successor to the fixed 16-slot bridge used behind the AHB-Lite/APB BFM.
- Decodes the slot from HADDR and runs one APB transfer per AHB NONSEQ/SEQ transfer.
- Adds byte strobes, protection pass-through, the two-cycle AHB error response, and unmapped-slot errors.
- Sits between the BFM or system AHB fabric and the peripheral APB slaves.

---
 rtl/ahbl_apb_pkg.sv | 46 ++++
 rtl/ahbl_apb_slot_dec.sv | 34 +++
 rtl/ahbl_apb_bridge_mc.sv | 262 ++++++++++++++++++++++++++
 tb/tb_ahbl_apb_bridge_mc.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahbl_apb_pkg.sv
// ----------------------------------------------------------------------------
// ahbl_apb_pkg
// Shared definitions for the AHB-Lite to multi-slot APB bridge:
//   - state_e      : bridge FSM states
//   - HTRANS_*     : AHB transfer type encodings
//   - HRESP_*      : AHB-Lite response encodings
//   - HSIZE_*      : AHB transfer size encodings
//   - size_to_strb : APB byte strobes from HSIZE and the low address bits
// ----------------------------------------------------------------------------
package ahbl_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Sizes wider than a word on this 32-bit data path enable every lane.
    function automatic logic [3:0] size_to_strb(input logic [2:0] hsize,
                                                input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (hsize)
            HSIZE_BYTE: strb = 4'b0001 << addr_lo;
            HSIZE_HALF: strb = 4'b0011 << {addr_lo[1], 1'b0};
            HSIZE_WORD: strb = 4'b1111;
            default:    strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/ahbl_apb_slot_dec.sv
// ----------------------------------------------------------------------------
// ahbl_apb_slot_dec
// Combinational slot decoder: turns the 5-bit slot index field of HADDR into
// a one-hot PSEL vector and flags indices that have no PSEL line.
// Parameters: APB_SLOTS (1..32), SLOT_SHIFT (LSB of the index field).
// Ports:
//   slot_field  in  HADDR[SLOT_SHIFT+4:SLOT_SHIFT]
//   psel_onehot out one-hot select, all zero when unmapped
//   unmapped    out index >= APB_SLOTS
// ----------------------------------------------------------------------------
module ahbl_apb_slot_dec
    import ahbl_apb_pkg::*;
#(
    parameter int APB_SLOTS  = 16,
    parameter int SLOT_SHIFT = 8
) (
    input  logic [SLOT_SHIFT+4:SLOT_SHIFT] slot_field,
    output logic [APB_SLOTS-1:0]           psel_onehot,
    output logic                           unmapped
);

    logic [4:0] slot_idx;

    assign slot_idx = slot_field;
    assign unmapped = (32'(slot_idx) >= 32'(APB_SLOTS));

    genvar gi;
    generate
        for (gi = 0; gi < APB_SLOTS; gi++) begin : g_psel
            assign psel_onehot[gi] = (slot_idx == 5'(gi));
        end
    endgenerate

endmodule

// File: rtl/ahbl_apb_bridge_mc.sv
// ----------------------------------------------------------------------------
// ahbl_apb_bridge_mc
// AHB-Lite slave to multi-slot APB3/APB4 master bridge. Each accepted
// NONSEQ/SEQ transfer becomes one APB transfer to the slot selected by
// HADDR[SLOT_SHIFT+4:SLOT_SHIFT]; unmapped slots and PSLVERR produce the
// two-cycle AHB ERROR response.
//
// Optional build macro: AHBL_APB_TIMEOUT_EN
//   defined   - ACCESS is abandoned (ERR1) after TIMEOUT_CYCLES cycles with
//               PREADY low; PREADY in the final cycle still completes normally.
//   undefined - ACCESS waits for PREADY indefinitely.
//
// Ports:
//   HCLK, HRESET (sync, active high)
//   AHB side : HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HWDATA, HREADYIN
//              -> HREADYOUT, HRESP, HRDATA
//   APB side : PSEL[APB_SLOTS], PADDR, PENABLE, PWRITE, PWDATA, PSTRB, PPROT
//              <- PRDATA, PREADY, PSLVERR
// ----------------------------------------------------------------------------
module ahbl_apb_bridge_mc
    import ahbl_apb_pkg::*;
#(
    parameter int APB_SLOTS      = 16,
    parameter int SLOT_SHIFT     = 8,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 HSEL,
    input  logic [ADDR_W-1:0]    HADDR,
    input  logic [1:0]           HTRANS,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic [3:0]           HPROT,
    input  logic [31:0]          HWDATA,
    input  logic                 HREADYIN,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [31:0]          HRDATA,
    output logic [APB_SLOTS-1:0] PSEL,
    output logic [ADDR_W-1:0]    PADDR,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [31:0]          PWDATA,
    output logic [3:0]           PSTRB,
    output logic [2:0]           PPROT,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    // Elaboration-time guard against parameter sets the decoder cannot serve.
    generate
        if (APB_SLOTS < 1 || APB_SLOTS > 32 || SLOT_SHIFT + 5 > ADDR_W ||
            TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("ahbl_apb_bridge_mc: illegal parameter combination");
        end
    endgenerate

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   write_q, write_d;
    logic [3:0]             strb_q, strb_d;
    logic [2:0]             pprot_q, pprot_d;
    logic [APB_SLOTS-1:0]   psel_q, psel_d;
    logic                   unmapped_q, unmapped_d;
    logic [31:0]            pwdata_q, pwdata_d;
    logic [31:0]            hrdata_q, hrdata_d;

    logic [APB_SLOTS-1:0]   dec_psel;
    logic                   dec_unmapped;
    logic                   trans_active;
    logic                   accept;
    logic                   unused_hprot;

    // Only the privileged and data/opcode bits map onto PPROT.
    assign unused_hprot = ^HPROT[3:2];

    ahbl_apb_slot_dec #(
        .APB_SLOTS  (APB_SLOTS),
        .SLOT_SHIFT (SLOT_SHIFT)
    ) u_slot_dec (
        .slot_field  (HADDR[SLOT_SHIFT+4:SLOT_SHIFT]),
        .psel_onehot (dec_psel),
        .unmapped    (dec_unmapped)
    );

    always_comb begin
        trans_active = 1'b0;
        case (HTRANS)
            HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  trans_active = 1'b0;
            default:                   trans_active = 1'b0;
        endcase
    end

    // An address phase can only be taken while we are driving HREADYOUT high.
    // ERR2 is such a cycle too, so a master that does not cancel after an
    // error still gets its next transfer accepted rather than silently lost.
    assign accept = HSEL && HREADYIN && trans_active &&
                    (state_q == ST_IDLE || state_q == ST_ERR2);

`ifdef AHBL_APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_hit;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ST_SETUP) begin
            tmo_cnt_d = '0;
        end else if (state_q == ST_ACCESS) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // The counter holds the number of ACCESS cycles already spent, so this
    // fires in the TIMEOUT_CYCLES-th ACCESS cycle.
    assign timeout_hit = (state_q == ST_ACCESS) &&
                         (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (HWRITE) begin
                        state_d = ST_WDATA;
                    end else if (dec_unmapped) begin
                        state_d = ST_ERR1;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_WDATA:  state_d = unmapped_q ? ST_ERR1 : ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY) begin
                    state_d = PSLVERR ? ST_ERR1 : ST_IDLE;
                end
`ifdef AHBL_APB_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = ST_ERR1;
                end
`endif
            end
            ST_ERR1:   state_d = ST_ERR2;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        PSEL      = '0;
        PENABLE   = 1'b0;
        case (state_q)
            ST_WDATA:  HREADYOUT = 1'b0;
            ST_SETUP: begin
                HREADYOUT = 1'b0;
                PSEL      = psel_q;
            end
            ST_ACCESS: begin
                HREADYOUT = 1'b0;
                PSEL      = psel_q;
                PENABLE   = 1'b1;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2:   HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

    // ---------------- Datapath next values ----------------
    // Captured fields only change on accept, which can never happen between
    // SETUP and the end of ACCESS, so the APB address/control stay stable.
    always_comb begin
        addr_d     = addr_q;
        write_d    = write_q;
        strb_d     = strb_q;
        pprot_d    = pprot_q;
        psel_d     = psel_q;
        unmapped_d = unmapped_q;
        pwdata_d   = pwdata_q;
        hrdata_d   = hrdata_q;

        if (accept) begin
            addr_d     = HADDR;
            write_d    = HWRITE;
            strb_d     = HWRITE ? size_to_strb(HSIZE, HADDR[1:0]) : 4'b0000;
            pprot_d    = {~HPROT[0], 1'b0, HPROT[1]};
            psel_d     = dec_psel;
            unmapped_d = dec_unmapped;
        end

        // WDATA is the AHB data phase of a write.
        if (state_q == ST_WDATA) begin
            pwdata_d = HWDATA;
        end

        if (state_q == ST_ACCESS && PREADY && !PSLVERR && !write_q) begin
            hrdata_d = PRDATA;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_q     <= '0;
            write_q    <= 1'b0;
            strb_q     <= '0;
            pprot_q    <= '0;
            psel_q     <= '0;
            unmapped_q <= 1'b0;
            pwdata_q   <= '0;
            hrdata_q   <= '0;
        end else begin
            addr_q     <= addr_d;
            write_q    <= write_d;
            strb_q     <= strb_d;
            pprot_q    <= pprot_d;
            psel_q     <= psel_d;
            unmapped_q <= unmapped_d;
            pwdata_q   <= pwdata_d;
            hrdata_q   <= hrdata_d;
        end
    end

    assign HRDATA = hrdata_q;
    assign PADDR  = addr_q;
    assign PWRITE = write_q;
    assign PWDATA = pwdata_q;
    assign PSTRB  = strb_q;
    assign PPROT  = pprot_q;

endmodule

// File: tb/tb_ahbl_apb_bridge_mc.sv
// ----------------------------------------------------------------------------
// tb_ahbl_apb_bridge_mc
// Self-checking bench for ahbl_apb_bridge_mc (APB_SLOTS=16, SLOT_SHIFT=8).
// Directed vector table, hand-written corner sequences and randomized
// transfers checked against a transaction-level reference model.
// ----------------------------------------------------------------------------
module tb_ahbl_apb_bridge_mc;

`ifdef AHBL_APB_TIMEOUT_EN
    localparam int TO    = 4;
    localparam int STALL = 2;
`else
    localparam int TO    = 256;
    localparam int STALL = 5;
`endif

    logic        HCLK, HRESET, HSEL, HWRITE, HREADYIN, HREADYOUT, HRESP;
    logic        PENABLE, PWRITE, PREADY, PSLVERR;
    logic [31:0] HADDR, HWDATA, HRDATA, PADDR, PWDATA, PRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, PPROT;
    logic [3:0]  HPROT, PSTRB;
    logic [15:0] PSEL;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] hr_model;

    typedef struct {
        int          ws;
        int          psel_cyc;
        int          pen_cyc;
        logic [31:0] psel_or;
        logic        stable;
        logic [31:0] paddr;
        logic        pwrite;
        logic [3:0]  pstrb;
        logic [31:0] pwdata;
        logic [2:0]  pprot;
        logic        resp_prev;
        logic        resp_final;
        logic [31:0] hrdata;
        logic        timeout;
    } xfer_obs_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  prot;
        logic [31:0] wdata;
        int          waits;
        logic        err;
        logic [31:0] rdata;
        logic [15:0] e_psel;
        logic [3:0]  e_strb;
        int          e_ws;
        logic        e_resp;
        logic [31:0] e_hrdata;
        logic [2:0]  e_pprot;
    } vec_t;

    vec_t vecs[8];

    ahbl_apb_bridge_mc #(
        .APB_SLOTS      (16),
        .SLOT_SHIFT     (8),
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HPROT     (HPROT),
        .HWDATA    (HWDATA),
        .HREADYIN  (HREADYIN),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .PSEL      (PSEL),
        .PADDR     (PADDR),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PPROT     (PPROT),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic wr, input logic [31:0] addr,
                           input logic [2:0] size, input logic [3:0] prot,
                           input logic [31:0] wdata, input int waits, input logic err,
                           input logic [31:0] rdata, input logic [15:0] e_psel,
                           input logic [3:0] e_strb, input int e_ws, input logic e_resp,
                           input logic [31:0] e_hrdata, input logic [2:0] e_pprot);
        vecs[i].wr = wr;         vecs[i].addr = addr;     vecs[i].size = size;
        vecs[i].prot = prot;     vecs[i].wdata = wdata;   vecs[i].waits = waits;
        vecs[i].err = err;       vecs[i].rdata = rdata;   vecs[i].e_psel = e_psel;
        vecs[i].e_strb = e_strb; vecs[i].e_ws = e_ws;     vecs[i].e_resp = e_resp;
        vecs[i].e_hrdata = e_hrdata;                      vecs[i].e_pprot = e_pprot;
    endtask

    task automatic idle_cycle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        step();
    endtask

    // Drives one AHB transfer starting in the current (HREADYOUT=1) cycle and
    // acts as the APB slave: PREADY stays low for 'waits' ACCESS cycles.
    // Returns at the completion cycle (first cycle with HREADYOUT=1).
    task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                            input logic [3:0] prot, input logic [31:0] wdata, input int waits,
                            input logic err, input logic [31:0] rdata, output xfer_obs_t o);
        int   acc;
        int   cyc;
        logic in_apb;
        o.ws = 0; o.psel_cyc = 0; o.pen_cyc = 0; o.psel_or = 0; o.stable = 1'b1;
        o.paddr = 0; o.pwrite = 0; o.pstrb = 0; o.pwdata = 0; o.pprot = 0;
        o.resp_prev = 0; o.resp_final = 0; o.hrdata = 0; o.timeout = 0;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = addr; HSIZE = size;
        HPROT = prot; HREADYIN = 1'b1; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = rdata;
        acc = 0; cyc = 0; in_apb = 1'b0;
        do begin
            step();
            cyc++;
            if (cyc == 1) begin
                // data phase: scramble the address-phase signals to prove capture
                HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
                HADDR = $urandom; HWRITE = ~wr; HSIZE = 3'($urandom); HPROT = 4'($urandom);
            end else if (cyc == 2) begin
                HWDATA = ~wdata;
            end
            if (HREADYOUT) begin
                o.resp_final = HRESP;
                o.hrdata     = HRDATA;
            end else begin
                o.ws++;
                o.resp_prev = HRESP;
            end
            if (PSEL != 0) begin
                o.psel_or = o.psel_or | 32'(PSEL);
                o.psel_cyc++;
                if (!in_apb) begin
                    in_apb = 1'b1;
                    o.paddr = PADDR; o.pwrite = PWRITE; o.pstrb = PSTRB;
                    o.pwdata = PWDATA; o.pprot = PPROT;
                end else if (PADDR !== o.paddr || PWRITE !== o.pwrite || PSTRB !== o.pstrb ||
                             PWDATA !== o.pwdata || PPROT !== o.pprot) begin
                    o.stable = 1'b0;
                end
            end
            if (PENABLE) begin
                o.pen_cyc++;
                acc++;
                PREADY  = (acc > waits);
                PSLVERR = err && (acc > waits);
            end else begin
                PREADY  = 1'b0;
                PSLVERR = 1'b0;
            end
        end while (!HREADYOUT && cyc < 64);
        if (!HREADYOUT) o.timeout = 1'b1;
        PREADY = 1'b0; PSLVERR = 1'b0;
    endtask

    task automatic check_obs(input string tag, input xfer_obs_t o, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata, input int waits,
                             input logic [31:0] e_psel, input logic [3:0] e_strb, input int e_ws,
                             input logic e_resp, input logic [31:0] e_hrdata,
                             input logic [2:0] e_pprot);
        logic mapped;
        mapped = (e_psel != 0);
        $display("[TB] %s %s addr=%08h ws=%0d psel=%04h resp=%0d hrdata=%08h",
                 tag, wr ? "WR" : "RD", addr, o.ws, o.psel_or, o.resp_final, o.hrdata);
        check({tag, ".bounded"},   32'(o.timeout), 32'd0);
        check({tag, ".wait_st"},   32'(o.ws), 32'(e_ws));
        check({tag, ".resp_end"},  32'(o.resp_final), 32'(e_resp));
        check({tag, ".resp_prev"}, 32'(o.resp_prev), 32'(e_resp));
        check({tag, ".psel"},      o.psel_or, e_psel);
        check({tag, ".hrdata"},    o.hrdata, e_hrdata);
        check({tag, ".pen_cyc"},   32'(o.pen_cyc), mapped ? 32'(waits + 1) : 32'd0);
        check({tag, ".psel_cyc"},  32'(o.psel_cyc), mapped ? 32'(waits + 2) : 32'd0);
        if (mapped) begin
            check({tag, ".stable"}, 32'(o.stable), 32'd1);
            check({tag, ".paddr"},  o.paddr, addr);
            check({tag, ".pwrite"}, 32'(o.pwrite), 32'(wr));
            check({tag, ".pstrb"},  32'(o.pstrb), 32'(e_strb));
            check({tag, ".pprot"},  32'(o.pprot), 32'(e_pprot));
            if (wr) check({tag, ".pwdata"}, o.pwdata, wdata);
        end
    endtask

    // Reference model: byte-lane strobes from transfer size and address.
    function automatic logic [3:0] model_strb(input logic wr, input logic [31:0] addr,
                                              input logic [2:0] size);
        int bytes;
        int lane;
        if (!wr) return 4'h0;
        bytes = (size >= 3'd2) ? 4 : (1 << size);
        if (bytes == 4) return 4'hF;
        lane = ((int'(addr % 4)) / bytes) * bytes;
        return 4'(((1 << bytes) - 1) << lane);
    endfunction

    initial begin
        xfer_obs_t   o;
        logic        wr, err, mapped, is_err;
        logic [31:0] addr, wdata, rdata, e_psel;
        logic [2:0]  size;
        logic [3:0]  prot;
        int          idx, waits, e_ws, cnt;

        HRESET = 1'b1; HSEL = 1'b0; HADDR = 0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'd2; HPROT = 4'd0; HWDATA = 0; HREADYIN = 1'b1;
        PRDATA = 0; PREADY = 1'b0; PSLVERR = 1'b0;
        hr_model = 32'h0;

        // Directed vectors: inputs then hand-derived expectations.
        set_vec(0, 0, 32'h0000_0304, 3'd2, 4'b0011, 32'h0, 0, 0, 32'hCAFE_0001,
                16'h0008, 4'b0000, 2, 0, 32'hCAFE_0001, 3'b001);
        set_vec(1, 1, 32'h0000_0102, 3'd0, 4'b0000, 32'h00AB_0000, 0, 0, 32'h0,
                16'h0002, 4'b0100, 3, 0, 32'hCAFE_0001, 3'b100);
        set_vec(2, 1, 32'h0000_050A, 3'd1, 4'b0010, 32'h1234_5678, STALL, 0, 32'h0,
                16'h0020, 4'b1100, 3 + STALL, 0, 32'hCAFE_0001, 3'b101);
        set_vec(3, 0, 32'h0000_0710, 3'd2, 4'b0001, 32'h0, 0, 1, 32'hDEAD_BEEF,
                16'h0080, 4'b0000, 3, 1, 32'hCAFE_0001, 3'b000);
        set_vec(4, 0, 32'h0000_1400, 3'd2, 4'b0000, 32'h0, 0, 0, 32'h5555_5555,
                16'h0000, 4'b0000, 1, 1, 32'hCAFE_0001, 3'b100);
        set_vec(5, 1, 32'h0000_14F0, 3'd2, 4'b0000, 32'h7777_7777, 0, 0, 32'h0,
                16'h0000, 4'b1111, 2, 1, 32'hCAFE_0001, 3'b100);
        set_vec(6, 0, 32'h0000_0F00, 3'd2, 4'b0000, 32'h0, 1, 0, 32'h0BAD_F00D,
                16'h8000, 4'b0000, 3, 0, 32'h0BAD_F00D, 3'b100);
        set_vec(7, 1, 32'h0000_0203, 3'd0, 4'b0000, 32'hAA00_0000, 0, 0, 32'h0,
                16'h0004, 4'b1000, 3, 0, 32'h0BAD_F00D, 3'b100);

        step(); step();
        check("rst.hreadyout", 32'(HREADYOUT), 32'd1);
        check("rst.hresp",     32'(HRESP), 32'd0);
        check("rst.hrdata",    HRDATA, 32'd0);
        check("rst.psel",      32'(PSEL), 32'd0);
        check("rst.penable",   32'(PENABLE), 32'd0);
        check("rst.pwrite",    32'(PWRITE), 32'd0);
        check("rst.paddr",     PADDR, 32'd0);
        check("rst.pwdata",    PWDATA, 32'd0);
        check("rst.pstrb",     32'(PSTRB), 32'd0);
        check("rst.pprot",     32'(PPROT), 32'd0);
        HRESET = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            run_xfer(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].prot, vecs[i].wdata,
                     vecs[i].waits, vecs[i].err, vecs[i].rdata, o);
            check_obs($sformatf("vec%0d", i), o, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                      vecs[i].waits, 32'(vecs[i].e_psel), vecs[i].e_strb, vecs[i].e_ws,
                      vecs[i].e_resp, vecs[i].e_hrdata, vecs[i].e_pprot);
            idle_cycle();
        end
        hr_model = 32'h0BAD_F00D;

        // IDLE, BUSY and not-ready address phases get no APB activity.
        HSEL = 1'b1; HADDR = 32'h0000_0304; HWRITE = 1'b0; HTRANS = 2'b01; step();
        check("busy.hreadyout", 32'(HREADYOUT), 32'd1);
        check("busy.psel",      32'(PSEL), 32'd0);
        HTRANS = 2'b10; HREADYIN = 1'b0; step();
        HTRANS = 2'b00; HREADYIN = 1'b1; step();
        check("notready.hreadyout", 32'(HREADYOUT), 32'd1);
        check("notready.psel",      32'(PSEL), 32'd0);
        check("notready.hresp",     32'(HRESP), 32'd0);
        $display("[TB] idle/busy/not-ready address phases ignored");
        HSEL = 1'b0;

        // Back-to-back: the write is issued in the read's completion cycle.
        run_xfer(0, 32'h0000_0100, 3'd2, 4'b0000, 32'h0, 0, 0, 32'h1111_0001, o);
        hr_model = 32'h1111_0001;
        check_obs("b2b_rd", o, 0, 32'h0000_0100, 32'h0, 0, 32'h0002, 4'h0, 2, 0,
                  hr_model, 3'b100);
        run_xfer(1, 32'h0000_0200, 3'd2, 4'b0001, 32'h2222_0002, 0, 0, 32'h0, o);
        check_obs("b2b_wr", o, 1, 32'h0000_0200, 32'h2222_0002, 0, 32'h0004, 4'hF, 3, 0,
                  hr_model, 3'b000);
        idle_cycle();

        // Reset during ACCESS: PSEL drops at that edge, no response follows.
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0000_0304; HSIZE = 3'd2;
        PREADY = 1'b0;
        step();
        HSEL = 1'b0; HTRANS = 2'b00;
        cnt = 0;
        while (!PENABLE && cnt < 10) begin
            step();
            cnt++;
        end
        check("rstmid.in_access", 32'(PENABLE), 32'd1);
        HRESET = 1'b1;
        step();
        check("rstmid.psel",      32'(PSEL), 32'd0);
        check("rstmid.penable",   32'(PENABLE), 32'd0);
        check("rstmid.hreadyout", 32'(HREADYOUT), 32'd1);
        check("rstmid.hresp",     32'(HRESP), 32'd0);
        check("rstmid.hrdata",    HRDATA, 32'd0);
        HRESET = 1'b0;
        step();
        check("rstmid.after_hreadyout", 32'(HREADYOUT), 32'd1);
        check("rstmid.after_psel",      32'(PSEL), 32'd0);
        $display("[TB] reset during ACCESS abandons the transfer");
        hr_model = 32'h0;

`ifdef AHBL_APB_TIMEOUT_EN
        run_xfer(0, 32'h0000_0200, 3'd2, 4'b0000, 32'h0, 1000, 0, 32'h0, o);
        $display("[TB] timeout RD addr=00000200 ws=%0d pen=%0d resp=%0d",
                 o.ws, o.pen_cyc, o.resp_final);
        check("tmo.bounded",  32'(o.timeout), 32'd0);
        check("tmo.pen_cyc",  32'(o.pen_cyc), 32'(TO));
        check("tmo.wait_st",  32'(o.ws), 32'(TO + 2));
        check("tmo.resp_end", 32'(o.resp_final), 32'd1);
        check("tmo.psel",     o.psel_or, 32'h0004);
        check("tmo.hrdata",   o.hrdata, hr_model);
        idle_cycle();
`endif

        // Randomized transfers against the transaction-level model.
        for (int n = 0; n < 40; n++) begin
            idx   = int'($urandom_range(0, 21));
            addr  = ($urandom & 32'hFFFF_E0FF) | (32'(idx) << 8);
            wr    = 1'($urandom);
            size  = 3'($urandom_range(0, 3));
            prot  = 4'($urandom);
            wdata = $urandom;
            rdata = $urandom;
            waits = int'($urandom_range(0, 2));
            err   = ($urandom_range(0, 5) == 0);
            mapped = (idx < 16);
            is_err = !mapped || err;
            e_psel = mapped ? (32'd1 << idx) : 32'd0;
            e_ws   = (wr ? 1 : 0) + (mapped ? 2 + waits : 0) + (is_err ? 1 : 0);
            if (!wr && mapped && !err) hr_model = rdata;
            run_xfer(wr, addr, size, prot, wdata, waits, err, rdata, o);
            check_obs($sformatf("rnd%0d", n), o, wr, addr, wdata, waits, e_psel,
                      model_strb(wr, addr, size), e_ws, is_err, hr_model,
                      {~prot[0], 1'b0, prot[1]});
            idle_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
